cronometro_dois_digitos: RTL and testbench
==========================================

Name: cronometro_dois_digitos

Overview:
Two-digit seconds stopwatch/countdown that produces the binary value driven into the two-digit 7-segment decoder stage (units/tens) downstream. It divides the board clock into a 1 s tick, runs an up-counter (wrapping) or a down-counter (stopping at zero), and is controlled by three push-button events. The output `valor` is a 32-bit binary number in 0..MAX_CONTAGEM; it connects directly to the decoder's 32-bit input.

Parameters:
TICKS_POR_SEGUNDO, 50000000, clock cycles per count step; legal range ≥ 2. Benches use 4.
MAX_CONTAGEM, 99, highest value ever presented on `valor`; legal range 1..99.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  synchronous, active-low reset.
botao_iniciar  input  1  active-high start/resume request; asynchronous level.
botao_parar  input  1  active-high pause request; asynchronous level.
botao_zerar  input  1  active-high clear/reload request; asynchronous level.
decrescente  input  1  0 = count up, 1 = count down; sampled only on a zerar event and at reset.
carga  input  7  countdown start value; saturated to MAX_CONTAGEM.
valor  output  32  current count, zero-extended to 32 bits.
tick_segundo  output  1  one-cycle pulse on each count step.
rodando  output  1  high in state CONTANDO.
fim  output  1  high in state FIM.

Behaviour:
- Reset (reset_n = 0 at a rising edge):
  - state = OCIOSO, prescaler = 0, synchronizers = 0, tick_segundo = 0, rodando = 0, fim = 0.
  - Direction register := decrescente.
  - valor := 0 in up mode; valor := min(carga, MAX_CONTAGEM) in down mode.
  - Reset overrides every other event, including reset asserted mid-count.
- Button inputs:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector, giving one event per press.
  - A button going high before edge N produces its effect (state/valor) at edge N+2.
  - Holding a button high produces no further events.
- Event priority when events coincide: zerar > parar > iniciar.
- FSM states and transitions:
  - OCIOSO: iniciar -> CONTANDO. Prescaler is cleared on this transition.
  - CONTANDO:
    - Prescaler increments each cycle.
    - At TICKS_POR_SEGUNDO-1 the prescaler returns to 0, tick_segundo = 1 for that cycle, and valor steps.
    - parar -> PAUSADO.
  - PAUSADO: prescaler and valor hold (partial second retained). iniciar -> CONTANDO, resuming from the retained prescaler value.
  - FIM: valor = 0, fim = 1. Only zerar (or reset) leaves this state. iniciar and parar are ignored.
  - zerar, from any state:
    - state -> OCIOSO, prescaler = 0.
    - Direction register := decrescente.
    - valor := 0 (up) or min(carga, MAX_CONTAGEM) (down).
- Counting rules:
  - Up mode: valor = MAX_CONTAGEM steps to 0 and counting continues.
  - Down mode: valor = 1 steps to 0 and the state becomes FIM at the same edge. tick_segundo pulses on that step.
  - Down mode with valor already 0 and an iniciar event: go straight to FIM at the event edge, with no tick.
- Output invariants:
  - valor never exceeds MAX_CONTAGEM; bits 31:7 are always 0.
  - tick_segundo is never high outside CONTANDO.
- Changing `carga` or `decrescente` has no effect until the next zerar event or reset.

Test Plan:
All scenarios use TICKS_POR_SEGUNDO = 4 and MAX_CONTAGEM = 99.
1. Reset with decrescente = 0, then press iniciar -> rodando high at the 3rd edge after the press; valor goes 0 -> 1 -> 2, with one tick_segundo pulse every 4 cycles and no other tick_segundo activity.
2. Up mode with valor = 99 -> the next tick gives valor = 0 and rodando stays 1.
3. While counting, press parar 2 cycles into a second, wait 20 cycles, then press iniciar -> valor is unchanged during the pause; the next step occurs 2 cycles after resume (partial second retained).
4. Set decrescente = 1, carga = 3, press zerar, then iniciar -> valor shows 3, 2, 1, 0. At 0, fim = 1 and rodando = 0. A further iniciar leaves the outputs unchanged. A zerar press returns valor to 3 with fim = 0.
5. Down mode with carga = 120, press zerar -> valor = 99.
6. Press iniciar, parar and zerar in the same cycle while counting -> OCIOSO, valor = 0 (zerar wins). Drive reset_n low mid-count -> all outputs take their reset values at the next edge.

Source files
------------

// File: rtl/cronometro_dois_digitos.sv
// Two-digit seconds stopwatch/countdown: 1 s prescaler, up (wrapping) or down (stop at zero)
// counter, driven by three synchronized push-button events. Output feeds the 7-segment decoder.
module cronometro_dois_digitos #(
  parameter int TICKS_POR_SEGUNDO = 50000000,
  parameter int MAX_CONTAGEM      = 99
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        botao_iniciar,
  input  logic        botao_parar,
  input  logic        botao_zerar,
  input  logic        decrescente,
  input  logic [6:0]  carga,
  output logic [31:0] valor,
  output logic        tick_segundo,
  output logic        rodando,
  output logic        fim
);

  localparam int              PW         = $clog2(TICKS_POR_SEGUNDO);
  localparam logic [PW-1:0]   PRESC_FIM  = PW'(TICKS_POR_SEGUNDO - 1);
  localparam logic [6:0]      VALOR_MAX  = 7'(MAX_CONTAGEM);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONTANDO = 2'd1;
  localparam logic [1:0] PAUSADO  = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  logic [2:0]    sync1_q, sync2_q, prev_q;
  logic [2:0]    evento;
  logic          evIniciar, evParar, evZerar;
  logic [1:0]    estado_q, estado_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    valor_q, valor_d;
  logic          desc_q, desc_d;
  logic [6:0]    cargaSat, valorInicial;
  logic          passo;

  // Bit order {zerar, parar, iniciar}; prev_q turns the synchronized level into a one-cycle event
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {botao_zerar, botao_parar, botao_iniciar};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign evento    = sync2_q & ~prev_q;
  assign evIniciar = evento[0];
  assign evParar   = evento[1];
  assign evZerar   = evento[2];

  assign cargaSat     = (carga > VALOR_MAX) ? VALOR_MAX : carga;
  assign valorInicial = decrescente ? cargaSat : 7'd0;

  // A pending zerar/parar pre-empts the step that would otherwise land on this edge
  assign passo = (estado_q == CONTANDO) && (presc_q == PRESC_FIM) && !evZerar && !evParar;

  always_comb begin
    estado_d = estado_q;
    presc_d  = presc_q;
    valor_d  = valor_q;
    desc_d   = desc_q;
    if (evZerar) begin
      estado_d = OCIOSO;
      presc_d  = '0;
      valor_d  = valorInicial;
      desc_d   = decrescente;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (!evParar && evIniciar) begin
            presc_d  = '0;
            estado_d = (desc_q && valor_q == 7'd0) ? FIM : CONTANDO;
          end
        end
        CONTANDO: begin
          if (evParar) begin
            estado_d = PAUSADO;
          end else if (presc_q == PRESC_FIM) begin
            presc_d = '0;
            if (desc_q) begin
              if (valor_q <= 7'd1) begin
                valor_d  = 7'd0;
                estado_d = FIM;
              end else begin
                valor_d = valor_q - 7'd1;
              end
            end else begin
              valor_d = (valor_q >= VALOR_MAX) ? 7'd0 : valor_q + 7'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSADO: begin
          if (!evParar && evIniciar) begin
            estado_d = (desc_q && valor_q == 7'd0) ? FIM : CONTANDO;
          end
        end
        FIM: begin
          valor_d = 7'd0;
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      presc_q  <= '0;
      valor_q  <= valorInicial;
      desc_q   <= decrescente;
    end else begin
      estado_q <= estado_d;
      presc_q  <= presc_d;
      valor_q  <= valor_d;
      desc_q   <= desc_d;
    end
  end

  assign valor        = {25'd0, valor_q};
  assign tick_segundo = passo;
  assign rodando      = (estado_q == CONTANDO);
  assign fim          = (estado_q == FIM);

endmodule

// File: tb/tb_cronometro_dois_digitos.sv
// Directed self-checking bench for cronometro_dois_digitos with a 4-cycle second.
module tb_cronometro_dois_digitos;

  logic        clock;
  logic        reset_n;
  logic        botao_iniciar;
  logic        botao_parar;
  logic        botao_zerar;
  logic        decrescente;
  logic [6:0]  carga;
  logic [31:0] valor;
  logic        tick_segundo;
  logic        rodando;
  logic        fim;

  int nAsserts = 0;
  int nFails   = 0;

  cronometro_dois_digitos #(
    .TICKS_POR_SEGUNDO(4),
    .MAX_CONTAGEM(99)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .botao_iniciar(botao_iniciar),
    .botao_parar(botao_parar),
    .botao_zerar(botao_zerar),
    .decrescente(decrescente),
    .carga(carga),
    .valor(valor),
    .tick_segundo(tick_segundo),
    .rodando(rodando),
    .fim(fim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the buttons, then advance one rising edge and settle 1 time unit past it
  task automatic applyStimulus(input logic ini, input logic par, input logic zer);
    botao_iniciar = ini;
    botao_parar   = par;
    botao_zerar   = zer;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    decrescente = 1'b0;
    carga = 7'd0;
    botao_iniciar = 1'b0;
    botao_parar = 1'b0;
    botao_zerar = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reset_valor", valor, 32'd0);
    checkOutput("reset_rodando", 32'(rodando), 32'd0);
    checkOutput("reset_fim", 32'(fim), 32'd0);
    checkOutput("reset_tick", 32'(tick_segundo), 32'd0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0);

    // Up-count start: effect two edges after the synchronizer captures the press
    applyStimulus(1, 0, 0);
    checkOutput("start_e1_rodando", 32'(rodando), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("start_e2_rodando", 32'(rodando), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("start_e3_rodando", 32'(rodando), 32'd1);
    checkOutput("start_e3_valor", valor, 32'd0);
    checkOutput("start_e3_tick", 32'(tick_segundo), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput("up_tick", 32'(tick_segundo), 32'((k % 4) == 3));
      checkOutput("up_valor", valor, 32'(k / 4));
    end

    // Pause two cycles into a second and resume with the partial second retained
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("pause_rodando", 32'(rodando), 32'd0);
    checkOutput("pause_valor", valor, 32'd2);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("pause_hold_valor", valor, 32'd2);
      checkOutput("pause_hold_tick", 32'(tick_segundo), 32'd0);
    end
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("resume_e2_rodando", 32'(rodando), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("resume_rodando", 32'(rodando), 32'd1);
    checkOutput("resume_valor", valor, 32'd2);
    checkOutput("resume_tick0", 32'(tick_segundo), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("resume_tick1", 32'(tick_segundo), 32'd1);
    checkOutput("resume_valor1", valor, 32'd2);
    applyStimulus(0, 0, 0);
    checkOutput("resume_step", valor, 32'd3);
    checkOutput("resume_step_tick", 32'(tick_segundo), 32'd0);

    // Up-mode wrap 99 -> 0
    for (int i = 0; i < 500 && valor != 32'd99; i++) applyStimulus(0, 0, 0);
    checkOutput("reach99", valor, 32'd99);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("wrap_tick", 32'(tick_segundo), 32'd1);
    checkOutput("wrap_pre_valor", valor, 32'd99);
    applyStimulus(0, 0, 0);
    checkOutput("wrap_valor", valor, 32'd0);
    checkOutput("wrap_rodando", 32'(rodando), 32'd1);
    repeat (4) applyStimulus(0, 0, 0);
    checkOutput("after_wrap_valor", valor, 32'd1);

    // All three buttons together: zerar wins
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("all3_e2_valor", valor, 32'd1);
    applyStimulus(0, 0, 0);
    checkOutput("all3_valor", valor, 32'd0);
    checkOutput("all3_rodando", 32'(rodando), 32'd0);
    checkOutput("all3_fim", 32'(fim), 32'd0);

    // Countdown from 3; direction/carga only take effect on zerar
    decrescente = 1'b1;
    carga = 7'd3;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("load_e2_valor", valor, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("load_valor", valor, 32'd3);
    checkOutput("load_fim", 32'(fim), 32'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("down_start_rodando", 32'(rodando), 32'd1);
    checkOutput("down_start_valor", valor, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput("down_valor", valor, 32'(3 - k / 4));
      checkOutput("down_tick", 32'(tick_segundo), 32'((k % 4) == 3));
      checkOutput("down_fim", 32'(fim), 32'(k >= 12));
      checkOutput("down_rodando", 32'(rodando), 32'(k < 12));
    end
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("fim_ini_fim", 32'(fim), 32'd1);
      checkOutput("fim_ini_valor", valor, 32'd0);
      checkOutput("fim_ini_rodando", 32'(rodando), 32'd0);
    end
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("fim_par_fim", 32'(fim), 32'd1);
    end
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reload_valor", valor, 32'd3);
    checkOutput("reload_fim", 32'(fim), 32'd0);
    checkOutput("reload_rodando", 32'(rodando), 32'd0);

    // Saturated load
    carga = 7'd120;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("sat_valor", valor, 32'd99);

    // Down mode from zero goes straight to FIM without a tick
    carga = 7'd0;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("zero_load_valor", valor, 32'd0);
    checkOutput("zero_load_fim", 32'(fim), 32'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("zero_e2_fim", 32'(fim), 32'd0);
    checkOutput("zero_e2_tick", 32'(tick_segundo), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("zero_fim", 32'(fim), 32'd1);
    checkOutput("zero_tick", 32'(tick_segundo), 32'd0);
    checkOutput("zero_rodando", 32'(rodando), 32'd0);

    // Reset mid-count overrides everything at the next edge
    carga = 7'd50;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("mid_load_valor", valor, 32'd50);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("mid_rodando", 32'(rodando), 32'd1);
    repeat (4) applyStimulus(0, 0, 0);
    checkOutput("mid_valor", valor, 32'd49);
    decrescente = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("sync_reset_wait", 32'(rodando), 32'd1);
    applyStimulus(0, 0, 0);
    checkOutput("midrst_valor", valor, 32'd0);
    checkOutput("midrst_rodando", 32'(rodando), 32'd0);
    checkOutput("midrst_fim", 32'(fim), 32'd0);
    checkOutput("midrst_tick", 32'(tick_segundo), 32'd0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
